// File: rtl/nsc_pkg.sv
// Shared definitions for the nsc_core CPU: default widths, opcode values and sequencer states.
package nsc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned OPC_W_DEF  = 4;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LDA = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_STA = 4;
  localparam int unsigned OP_LDI = 5;
  localparam int unsigned OP_JMP = 6;
  localparam int unsigned OP_JC  = 7;
  localparam int unsigned OP_JZ  = 8;
  localparam int unsigned OP_OUT = 14;
  localparam int unsigned OP_HLT = 15;

  typedef enum logic [2:0] {F0, F1, E0, E1, HALT} state_e;

endpackage

// File: rtl/nsc_alu.sv
// Combinational adder/subtractor for nsc_core; subtraction is a + ~b + 1 so carry=1 means no borrow.
module nsc_alu #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o,
  output logic         zero_o
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff              = sub_i ? ~b_i : b_i;
    {carry_o, sum_o}   = {1'b0, a_i} + {1'b0, b_eff} + (W+1)'(sub_i);
    zero_o             = (sum_o == '0);
  end

endmodule

// File: rtl/nsc_core.sv
// nsc_core: accumulator CPU with F0/F1/E0/E1/HALT sequencer and external synchronous-read RAM.
// Optional NSC_CORE_PAUSE_EN adds a 'pause' input that holds the core in F0.
module nsc_core
  import nsc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
`ifdef NSC_CORE_PAUSE_EN
  input  logic              pause,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted
);

  if (DATA_W != OPC_W + ADDR_W) begin : g_width_chk
    $fatal(1, "nsc_core: DATA_W must equal OPC_W + ADDR_W");
  end

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                c_q;
  logic                z_q;
  logic [DATA_W-1:0]   out_q;
  logic                outv_q;
  logic                halt_q;

  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;
  logic                pause_w;
  logic [DATA_W-1:0]   alu_sum;
  logic                alu_carry;
  logic                alu_zero;
  logic                unused_b;

`ifdef NSC_CORE_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign opcode   = ir_q[DATA_W-1 -: OPC_W];
  assign operand  = ir_q[ADDR_W-1:0];
  assign unused_b = ^b_q;

  // Execute states address the operand; fetch (and HALT) address the PC.
  assign mem_addr  = (state_q == E0 || state_q == E1) ? operand : pc_q;
  assign mem_we    = !reset && (state_q == E0) && (opcode == OPC_W'(OP_STA));
  assign mem_wdata = a_q;
  assign out_data  = out_q;
  assign out_valid = outv_q;
  assign halted    = halt_q;

  nsc_alu #(.W(DATA_W)) u_alu (
    .a_i     (a_q),
    .b_i     (mem_rdata),
    .sub_i   (opcode == OPC_W'(OP_SUB)),
    .sum_o   (alu_sum),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= F0;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
      outv_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      outv_q <= 1'b0;
      unique case (state_q)
        F0: if (!pause_w) state_q <= F1;
        F1: begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= E0;
        end
        E0: begin
          state_q <= F0;
          case (opcode)
            OPC_W'(OP_LDA), OPC_W'(OP_ADD), OPC_W'(OP_SUB): state_q <= E1;
            OPC_W'(OP_LDI): begin
              a_q <= DATA_W'(operand);
              z_q <= (operand == '0);
            end
            OPC_W'(OP_JMP): pc_q <= operand;
            OPC_W'(OP_JC):  if (c_q) pc_q <= operand;
            OPC_W'(OP_JZ):  if (z_q) pc_q <= operand;
            OPC_W'(OP_OUT): begin
              out_q  <= a_q;
              outv_q <= 1'b1;
            end
            OPC_W'(OP_HLT): begin
              state_q <= HALT;
              halt_q  <= 1'b1;
            end
            default: ;
          endcase
        end
        E1: begin
          state_q <= F0;
          if (opcode == OPC_W'(OP_LDA)) begin
            a_q <= mem_rdata;
            z_q <= (mem_rdata == '0);
          end else begin
            b_q <= mem_rdata;
            a_q <= alu_sum;
            c_q <= alu_carry;
            z_q <= alu_zero;
          end
        end
        HALT: ;
        default: state_q <= F0;
      endcase
    end
  end

endmodule

// File: doc/nsc_core.md
Name: nsc_core

Overview:
- Parametrised successor of the 8-bit NSC8 CPU.
- Holds accumulator A, B register, ALU, PC, IR, the ring-style sequencer and the output register in one block. Program/data RAM sits outside on a synchronous-read port.
- Generalises data and address width.
- Adds carry/zero flags, conditional jumps, HLT with a halted indication, and a one-cycle output-valid strobe.

Parameters:
- DATA_W, 8: data/instruction word width.
- ADDR_W, 4: memory address width; RAM depth is 2**ADDR_W.
- OPC_W, 4: opcode width. DATA_W must equal OPC_W+ADDR_W; the elaboration check is fatal otherwise.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- mem_addr  out  ADDR_W  RAM address; combinational from state/PC/IR.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_addr is presented.
- mem_wdata  out  DATA_W  write data; always equal to A.
- mem_we  out  1  write strobe; forced 0 while reset=1.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: PC, IR, A, B, C, Z, out_data = 0; out_valid = 0; halted = 0; state = F0. Reset aborts any instruction in progress. Reset has priority over every other event, including an in-flight STA write.
- Instruction word: opcode = IR[DATA_W-1 -: OPC_W]; operand = IR[ADDR_W-1:0].
- States: F0, F1, E0, E1, HALT.
  - F0: mem_addr = PC. Go to F1.
  - F1: IR <= mem_rdata; PC <= PC+1, wrapping from 2**ADDR_W-1 to 0. Go to E0.
  - E0: decode IR; actions per opcode below. Go to E1 for LDA/ADD/SUB, to HALT for HLT, else to F0.
  - E1: act on mem_rdata per opcode. Go to F0.
  - HALT: outputs hold; mem_we = 0. Leaves only via reset.
- Opcodes (values in package):
  - NOP 0: no action.
  - LDA 1: E0 mem_addr = operand. E1 A <= rdata; Z updated.
  - ADD 2: E0 mem_addr = operand. E1 B <= rdata; A <= A+rdata; C = carry out; Z updated.
  - SUB 3: E0 mem_addr = operand. E1 B <= rdata; A <= A+~rdata+1; C = carry out (1 means no borrow); Z updated.
  - STA 4: E0 mem_addr = operand, mem_we = 1 for one cycle.
  - LDI 5: A <= zero-extended operand; Z updated.
  - JMP 6: PC <= operand.
  - JC 7: PC <= operand if C = 1.
  - JZ 8: PC <= operand if Z = 1.
  - OUT 14: out_data <= A; out_valid = 1 on the following cycle only.
  - HLT 15: halted = 1 from the next cycle.
  - Undefined opcodes: treated as NOP.
- Cycle counts: LDA/ADD/SUB 4 cycles; all other instructions 3 cycles.
- Arithmetic: modulo 2**DATA_W. C changes only on ADD/SUB. Z changes on LDA/LDI/ADD/SUB.
- Jump to the current address is legal (spin loop).
- PC wrap: fetch at the last address is followed by a fetch from address 0.

Optional Feature:
- Macro NSC_CORE_PAUSE_EN.
- With it: extra input port pause (1 bit). While pause = 1 in F0, the core stays in F0 with no state change. pause is sampled only in F0, so an instruction already started completes.
- Without it: the port is absent and the core behaves as pause = 0.

Decomposition:
- Package nsc_pkg holds:
  - the opcode localparams;
  - the state enum {F0, F1, E0, E1, HALT};
  - the default widths.
- Natural sub-module: nsc_alu. It is combinational over a, b and sub, and returns sum, carry and zero.

Test Plan:
- Reset mid-STA: assert reset during E0 of STA -> mem_we = 0; next cycle PC = 0, A = 0, state = F0.
- Program LDA 14; ADD 15; OUT; HLT with RAM[14] = 0x05, RAM[15] = 0x07 -> out_data = 0x0C; out_valid high exactly 1 cycle; halted = 1 after 14 cycles; C = 0, Z = 0.
- ADD overflow, 0xFF + 0x01 -> A = 0x00, C = 1, Z = 1; a following JZ 9 loads PC = 9.
- SUB borrow, A = 0x03 minus 0x05 -> A = 0xFE, C = 0; JC is not taken, so PC advances by one.
- STA: LDI 9; STA 13 -> mem_we pulses once with mem_addr = 13, mem_wdata = 0x09.
- PC wrap: NOP at address 15 -> the next fetch presents mem_addr = 0.
